video_timing_gen: RTL and testbench

- Parametrised successor to the fixed-count sync/RGB tester.
- Derives a pixel-clock enable from the system clock and generates hsync/vsync/data-enable from programmable active, front-porch, sync and back-porch widths, with selectable sync polarity.
- Emits pixel coordinates to an external pixel source and accepts its RGB after a fixed latency. Pipelines the timing signals to match that latency.
- Quantises each colour channel from IN_BITS to OUT_BITS with rounding and saturation, and blanks colour outside the active area.

---
 rtl/video_timing_gen_if.sv | 21 ++
 rtl/video_timing_gen.sv | 96 +++++++++
 tb/tb_video_timing_gen.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/video_timing_gen_if.sv
// video_timing_gen_if: pixel-source request/response and video output bundle.
interface video_timing_gen_if #(
   parameter int IN_BITS  = 8,
   parameter int OUT_BITS = 2
);
   logic                pix_ce;
   logic [10:0]         pix_x;
   logic [9:0]          pix_y;
   logic                pix_req;
   logic [IN_BITS-1:0]  pix_r, pix_g, pix_b;
   logic                hsync, vsync, de, frame_start;
   logic [OUT_BITS-1:0] red, green, blue;
   modport master (
      output pix_ce, pix_x, pix_y, pix_req, hsync, vsync, de, red, green, blue, frame_start,
      input  pix_r, pix_g, pix_b
   );
   modport slave (
      input  pix_ce, pix_x, pix_y, pix_req, hsync, vsync, de, red, green, blue, frame_start,
      output pix_r, pix_g, pix_b
   );
endinterface

// File: rtl/video_timing_gen.sv
// video_timing_gen: programmable sync/DE timing with latency-matched, quantised RGB from an external pixel source.
module video_timing_gen #(
   parameter int CLK_DIV  = 8,
   parameter int H_ACTIVE = 200,
   parameter int H_FP     = 14,
   parameter int H_SYNC   = 30,
   parameter int H_BP     = 17,
   parameter int V_ACTIVE = 160,
   parameter int V_FP     = 0,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 6,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int PIX_LAT  = 2,
   parameter int IN_BITS  = 8,
   parameter int OUT_BITS = 2
) (
   input logic clk,
   input logic rst,
   input logic en,
   video_timing_gen_if.master vif
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW      = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   localparam int S       = IN_BITS - OUT_BITS;
   localparam int RND     = S > 0 ? 2 ** (S - 1) : 0;
   localparam int QMAX    = 2 ** OUT_BITS - 1;
   logic [DW-1:0] div;
   logic [10:0]   h_cnt;
   logic [9:0]    v_cnt;
   logic          ce, h_end;
   logic [3:0]    s0, dl;
   function automatic logic [OUT_BITS-1:0] quant(input logic [IN_BITS-1:0] v);
      logic [IN_BITS:0] t;
      t = ({1'b0, v} + (IN_BITS+1)'(RND)) >> S;
      return t > (IN_BITS+1)'(QMAX) ? OUT_BITS'(QMAX) : t[OUT_BITS-1:0];
   endfunction
   assign ce          = en && div == DW'(CLK_DIV - 1);
   assign h_end       = h_cnt == 11'(H_TOTAL - 1);
   assign vif.pix_ce  = ce;
   assign vif.pix_x   = h_cnt;
   assign vif.pix_y   = v_cnt;
   assign vif.pix_req = h_cnt < 11'(H_ACTIVE) && v_cnt < 10'(V_ACTIVE);
   // stage-0 flags carry "active" meaning; polarity is applied only at the output register
   assign s0 = {h_cnt >= 11'(H_ACTIVE + H_FP) && h_cnt < 11'(H_ACTIVE + H_FP + H_SYNC),
                v_cnt >= 10'(V_ACTIVE + V_FP) && v_cnt < 10'(V_ACTIVE + V_FP + V_SYNC),
                vif.pix_req,
                h_cnt == 11'd0 && v_cnt == 10'd0};
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         div   <= '0;
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (en) begin
         div <= ce ? '0 : div + 1'b1;
         if (ce) begin
            h_cnt <= h_end ? '0 : h_cnt + 1'b1;
            if (h_end) v_cnt <= v_cnt == 10'(V_TOTAL - 1) ? '0 : v_cnt + 1'b1;
         end
      end
   generate
      if (PIX_LAT == 0) begin : g_nolat
         assign dl = s0;
      end else begin : g_lat
         logic [3:0] pipe [PIX_LAT];
         always_ff @(posedge clk or posedge rst)
            if (rst) pipe <= '{default: '0};
            else if (ce) begin
               pipe[0] <= s0;
               for (int i = 1; i < PIX_LAT; i++) pipe[i] <= pipe[i-1];
            end
         assign dl = pipe[PIX_LAT-1];
      end
   endgenerate
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         vif.hsync       <= ~HS_POL;
         vif.vsync       <= ~VS_POL;
         vif.de          <= 1'b0;
         vif.red         <= '0;
         vif.green       <= '0;
         vif.blue        <= '0;
         vif.frame_start <= 1'b0;
      end else begin
         vif.frame_start <= ce && dl[0];
         if (ce) begin
            vif.hsync <= dl[3] ^ ~HS_POL;
            vif.vsync <= dl[2] ^ ~VS_POL;
            vif.de    <= dl[1];
            vif.red   <= dl[1] ? quant(vif.pix_r) : '0;
            vif.green <= dl[1] ? quant(vif.pix_g) : '0;
            vif.blue  <= dl[1] ? quant(vif.pix_b) : '0;
         end
      end
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed checks of sync/DE timing, colour quantisation, enable freeze and async reset.
module tb_video_timing_gen;
   logic clk = 1'b0, rst = 1'b1, en = 1'b1;
   always #5 clk = ~clk;
   video_timing_gen_if #(.IN_BITS(8), .OUT_BITS(2)) ia ();
   video_timing_gen_if #(.IN_BITS(8), .OUT_BITS(8)) ib ();
   // A: H_TOTAL 15, V_TOTAL 7, 2 clk/tick, latency 3 ticks; B: same raster, 3 clk/tick, latency 1 tick, high-true syncs
   video_timing_gen #(.CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4), .V_FP(0),
      .V_SYNC(2), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0), .PIX_LAT(2), .IN_BITS(8), .OUT_BITS(2))
      ua (.clk(clk), .rst(rst), .en(en), .vif(ia));
   video_timing_gen #(.CLK_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4), .V_FP(0),
      .V_SYNC(2), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1), .PIX_LAT(0), .IN_BITS(8), .OUT_BITS(8))
      ub (.clk(clk), .rst(rst), .en(en), .vif(ib));
   logic [7:0] lut [8]  = '{8'd0, 8'd31, 8'd32, 8'd95, 8'd96, 8'd159, 8'd224, 8'd255};
   logic [1:0] qtab [8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
   logic [6:0] sa0, sa1;
   logic       ea_de, eb_de;
   logic [1:0] ea_r, ea_g, ea_b;
   logic [7:0] eb_r, eb_g, eb_b;
   // pixel source for A: two tick registers give the required 2-tick response latency
   assign ia.pix_r = lut[sa1[5:3]];
   assign ia.pix_g = lut[~sa1[5:3]];
   assign ia.pix_b = lut[sa1[5:3] + sa1[2:0]];
   assign ib.pix_r = lut[ib.pix_x[2:0]];
   assign ib.pix_g = lut[~ib.pix_x[2:0]];
   assign ib.pix_b = lut[ib.pix_x[2:0] + ib.pix_y[2:0]];
   always @(posedge clk or posedge rst)
      if (rst) begin
         sa0 <= '0; sa1 <= '0;
         ea_de <= 1'b0; ea_r <= '0; ea_g <= '0; ea_b <= '0;
         eb_de <= 1'b0; eb_r <= '0; eb_g <= '0; eb_b <= '0;
      end else begin
         if (ia.pix_ce) begin
            sa0   <= {ia.pix_req, ia.pix_x[2:0], ia.pix_y[2:0]};
            sa1   <= sa0;
            ea_de <= sa1[6];
            ea_r  <= sa1[6] ? qtab[sa1[5:3]] : 2'd0;
            ea_g  <= sa1[6] ? qtab[~sa1[5:3]] : 2'd0;
            ea_b  <= sa1[6] ? qtab[sa1[5:3] + sa1[2:0]] : 2'd0;
         end
         if (ib.pix_ce) begin
            eb_de <= ib.pix_req;
            eb_r  <= ib.pix_req ? lut[ib.pix_x[2:0]] : 8'd0;
            eb_g  <= ib.pix_req ? lut[~ib.pix_x[2:0]] : 8'd0;
            eb_b  <= ib.pix_req ? lut[ib.pix_x[2:0] + ib.pix_y[2:0]] : 8'd0;
         end
      end
   int total = 0, bad = 0;
   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   // run statistics per signal: 0 ce, 1 hsync active, 2 vsync active, 3 de, 4 frame_start, 5 B hsync, 6 B vsync
   logic [6:0] sv;
   assign sv = {ib.vsync, ib.hsync, ia.frame_start, ia.de, ~ia.vsync, ~ia.hsync, ia.pix_ce};
   int cyc, fr [7], lr [7], per [7], nr [7], run [7], len [7], hi [7];
   bit prv [7];
   task automatic clr();
      cyc = 0;
      for (int i = 0; i < 7; i++) begin
         fr[i] = -1; lr[i] = 0; per[i] = 0; nr[i] = 0; run[i] = 0; len[i] = 0; hi[i] = 0; prv[i] = sv[i];
      end
   endtask
   task automatic step();
      @(negedge clk);
      if (en) cyc++;
      for (int i = 0; i < 7; i++) begin
         if (sv[i] && !prv[i]) begin
            nr[i]++;
            if (fr[i] < 0) fr[i] = cyc;
            else per[i] = cyc - lr[i];
            lr[i]  = cyc;
            run[i] = 0;
         end
         if (sv[i] && en) begin
            run[i]++;
            hi[i]++;
         end
         if (!sv[i] && prv[i]) len[i] = run[i];
         prv[i] = sv[i];
      end
      chk("a_de", int'(ia.de), int'(ea_de));
      chk("a_red", int'(ia.red), int'(ea_r));
      chk("a_green", int'(ia.green), int'(ea_g));
      chk("a_blue", int'(ia.blue), int'(ea_b));
      chk("b_de", int'(ib.de), int'(eb_de));
      chk("b_red", int'(ib.red), int'(eb_r));
      chk("b_green", int'(ib.green), int'(eb_g));
      chk("b_blue", int'(ib.blue), int'(eb_b));
      #1;
   endtask
   task automatic run_n(input int n);
      repeat (n) step();
   endtask
   task automatic chk_st(input string tag, input int i, input int f, input int p, input int l);
      chk({tag, "_first"}, fr[i], f);
      chk({tag, "_period"}, per[i], p);
      chk({tag, "_len"}, len[i], l);
   endtask
   initial begin
      int k;
      clr();
      run_n(3);
      chk("rst_ce", int'(ia.pix_ce), 0);
      chk("rst_hs", int'(ia.hsync), 1);
      chk("rst_vs", int'(ia.vsync), 1);
      chk("rst_fs", int'(ia.frame_start), 0);
      chk("rst_x", int'(ia.pix_x), 0);
      chk("rst_y", int'(ia.pix_y), 0);
      chk("rst_req", int'(ia.pix_req), 1);
      chk("rst_b_hs", int'(ib.hsync), 0);
      chk("rst_b_vs", int'(ib.vsync), 0);
      rst = 1'b0;
      clr();
      run_n(420);
      chk_st("ce", 0, 1, 2, 1);
      chk("ce_count", nr[0], 210);
      chk("ce_high", hi[0], 210);
      chk_st("hs", 1, 26, 30, 6);
      chk("hs_count", nr[1], 14);
      chk_st("vs", 2, 126, 210, 60);
      chk_st("de", 3, 6, 30, 16);
      chk("de_high", hi[3], 128);
      chk_st("fs", 4, 6, 210, 1);
      chk("fs_count", nr[4], 2);
      chk_st("b_hs", 5, 33, 45, 9);
      chk("b_vs_first", fr[6], 183);
      chk("b_vs_len", len[6], 90);
      clr();
      run_n(20);
      en = 1'b0;
      run_n(36);
      chk("frz_ce", int'(ia.pix_ce), 0);
      chk("frz_x", int'(ia.pix_x), 10);
      chk("frz_hs", int'(ia.hsync), 1);
      chk("frz_de", int'(ia.de), 1);
      run_n(1);
      en = 1'b1;
      run_n(130);
      chk_st("frz_hs", 1, 26, 30, 6);
      chk_st("frz_de", 3, 6, 30, 16);
      chk("frz_fs_first", fr[4], 6);
      chk("frz_vs_first", fr[2], 126);
      k = 0;
      while (ia.pix_y != 10'd2 && k < 1000) begin
         step();
         k++;
      end
      chk("wait_y2", int'(ia.pix_y), 2);
      #2 rst = 1'b1;
      #1;
      chk("arst_x", int'(ia.pix_x), 0);
      chk("arst_y", int'(ia.pix_y), 0);
      chk("arst_hs", int'(ia.hsync), 1);
      chk("arst_vs", int'(ia.vsync), 1);
      chk("arst_de", int'(ia.de), 0);
      chk("arst_red", int'(ia.red), 0);
      chk("arst_fs", int'(ia.frame_start), 0);
      chk("arst_ce", int'(ia.pix_ce), 0);
      chk("arst_b_hs", int'(ib.hsync), 0);
      run_n(2);
      rst = 1'b0;
      clr();
      run_n(10);
      chk("rel_ce_first", fr[0], 1);
      chk("rel_fs_first", fr[4], 6);
      chk("rel_de_first", fr[3], 6);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
